// File: rtl/isq_pkg.sv
// Shared types and defaults for the integer issue queue.
// Optional same-cycle bypass is controlled by the ISQ_BYPASS_EN macro in int_isq.
package isq_pkg;

    localparam int ISQ_DEPTH  = 8;
    localparam int ISQ_PREG_W = 6;

    typedef struct packed {
        logic [31:0]           pc;
        logic [31:0]           instr;
        logic [31:0]           offset;
        logic [2:0]            cx_type;
        logic [3:0]            alu_type;
        logic [2:0]            muldiv_type;
        logic                  is_load;
        logic                  is_store;
        logic [1:0]            size;
        logic                  need_to_wb;
        logic                  src1_is_reg;
        logic                  src2_is_reg;
        logic [ISQ_PREG_W-1:0] prs1;
        logic [ISQ_PREG_W-1:0] prs2;
        logic [ISQ_PREG_W-1:0] prd;
    } isq_payload_t;

endpackage

// File: rtl/int_isq_age_select.sv
// Oldest-ready picker: grants the requester that no other live requester is older than.
// older[j][i] set means entry j is older than entry i.
module age_select #(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] older [N],
    output logic [N-1:0] grant,
    output logic         any_valid
);

    logic [N-1:0] blocked_s;

    // An entry is blocked when any requesting entry is older than it
    always_comb begin
        blocked_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                blocked_s[i] = blocked_s[i] | (req[j] & older[j][i]);
            end
        end
        grant     = req & ~blocked_s;
        any_valid = |req;
    end

endmodule

// File: rtl/int_isq.sv
// Integer issue queue: wakeup tracking, age-ordered select, valid/ready issue.
// Define ISQ_BYPASS_EN to present an enqueue straight to issue when the queue is empty.
module int_isq
    import isq_pkg::*;
#(
    parameter int DEPTH  = ISQ_DEPTH,
    parameter int PREG_W = ISQ_PREG_W
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  isq_payload_t               enq_payload,
    input  logic                       enq_src1_ready,
    input  logic                       enq_src2_ready,
    input  logic                       wb0_valid,
    input  logic [PREG_W-1:0]          wb0_prd,
    input  logic                       wb1_valid,
    input  logic [PREG_W-1:0]          wb1_prd,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output isq_payload_t               issue_payload,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $bits(isq_payload_t);

    logic [DEPTH-1:0] valid_r, rdy1_r, rdy2_r;
    isq_payload_t     payload_r [DEPTH];
    logic [DEPTH-1:0] older_r [DEPTH];
    logic [CW-1:0]    count_r;

    logic [DEPTH-1:0] ready_s, grant_s, free_oh_s, wr_oh_s, issued_oh_s;
    logic             any_ready_s, enq_rdy1_s, enq_rdy2_s, enq_fire_s;
    logic             bypass_s, enq_write_s, q_issue_s;
    logic [PW-1:0]    mux_s;

    // Tag 0 is the architectural zero register and is never woken
    function automatic logic wake_hit(input logic [PREG_W-1:0] tag,
                                      input logic w0v, input logic [PREG_W-1:0] w0,
                                      input logic w1v, input logic [PREG_W-1:0] w1);
        return (tag != {PREG_W{1'b0}}) && ((w0v && (w0 == tag)) || (w1v && (w1 == tag)));
    endfunction

    age_select #(.N(DEPTH)) u_age_select (
        .req       (ready_s),
        .older     (older_r),
        .grant     (grant_s),
        .any_valid (any_ready_s)
    );

    // Entry readiness, enqueue acceptance, free-slot choice and bypass eligibility
    always_comb begin
        ready_s    = valid_r & rdy1_r & rdy2_r;
        enq_ready  = (count_r < CW'(DEPTH));
        enq_fire_s = enq_valid & enq_ready & ~flush;
        enq_rdy1_s = ~enq_payload.src1_is_reg | enq_src1_ready |
                     wake_hit(enq_payload.prs1, wb0_valid, wb0_prd, wb1_valid, wb1_prd);
        enq_rdy2_s = ~enq_payload.src2_is_reg | enq_src2_ready |
                     wake_hit(enq_payload.prs2, wb0_valid, wb0_prd, wb1_valid, wb1_prd);
        // Lowest clear bit of the valid vector, one-hot
        free_oh_s  = ~valid_r & (valid_r + {{(DEPTH-1){1'b0}}, 1'b1});
`ifdef ISQ_BYPASS_EN
        bypass_s   = enq_fire_s & (count_r == {CW{1'b0}}) & enq_rdy1_s & enq_rdy2_s;
`else
        bypass_s   = 1'b0;
`endif
    end

    // Issue mux and the per-slot write/clear masks for the next edge
    always_comb begin
        issue_valid = (any_ready_s | bypass_s) & ~flush;
        mux_s = {PW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            mux_s = mux_s | (payload_r[i] & {PW{grant_s[i]}});
        end
        if (bypass_s) begin
            issue_payload = enq_payload;
        end else begin
            issue_payload = isq_payload_t'(mux_s);
        end
        q_issue_s   = issue_valid & issue_ready & ~bypass_s;
        issued_oh_s = grant_s & {DEPTH{q_issue_s}};
        enq_write_s = enq_fire_s & ~(bypass_s & issue_ready);
        wr_oh_s     = free_oh_s & {DEPTH{enq_write_s}};
    end

    // Entry state, age matrix and occupancy
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_r <= {DEPTH{1'b0}};
            rdy1_r  <= {DEPTH{1'b0}};
            rdy2_r  <= {DEPTH{1'b0}};
            count_r <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                payload_r[i] <= {PW{1'b0}};
                older_r[i]   <= {DEPTH{1'b0}};
            end
        end else if (flush) begin
            valid_r <= {DEPTH{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_oh_s[i]) begin
                    valid_r[i]   <= 1'b1;
                    payload_r[i] <= enq_payload;
                    rdy1_r[i]    <= enq_rdy1_s;
                    rdy2_r[i]    <= enq_rdy2_s;
                    older_r[i]   <= {DEPTH{1'b0}};
                end else begin
                    valid_r[i] <= valid_r[i] & ~issued_oh_s[i];
                    rdy1_r[i]  <= rdy1_r[i] | (valid_r[i] & payload_r[i].src1_is_reg &
                                  wake_hit(payload_r[i].prs1, wb0_valid, wb0_prd, wb1_valid, wb1_prd));
                    rdy2_r[i]  <= rdy2_r[i] | (valid_r[i] & payload_r[i].src2_is_reg &
                                  wake_hit(payload_r[i].prs2, wb0_valid, wb0_prd, wb1_valid, wb1_prd));
                    // Every live entry becomes older than the newcomer
                    older_r[i] <= older_r[i] | (wr_oh_s & {DEPTH{valid_r[i]}});
                end
            end
            count_r <= count_r + CW'(enq_write_s) - CW'(q_issue_s);
        end
    end

    assign count = count_r;

endmodule

// File: doc/int_isq.md
# int_isq

Integer issue queue sitting directly upstream of the execution unit. It buffers renamed integer/branch/mul-div/memory micro-ops from dispatch, tracks physical source-register readiness via writeback wakeup, and each cycle issues the oldest ready entry to the execution unit through a valid/ready handshake. Issue order is age-ordered out-of-order; flush empties the queue.

## Interface
- `DEPTH`, 8: number of entries, 2..16.
- `PREG_W`, 6: physical register tag width.
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `flush` in 1: pipeline flush (redirect); empties the queue.
- `enq_valid` in 1: dispatch offers a micro-op.
- `enq_ready` out 1: queue accepts; equals `count < DEPTH`.
- `enq_payload` in `isq_payload_t`: pc, instr, offset, cx_type, alu_type, muldiv_type, is_load, is_store, size, need_to_wb, src1_is_reg, src2_is_reg, prs1, prs2, prd.
- `enq_src1_ready`, `enq_src2_ready` in 1 each: source ready at rename time.
- `wb0_valid`, `wb1_valid` in 1 each: writeback wakeup strobes.
- `wb0_prd`, `wb1_prd` in `PREG_W` each: tags being written back.
- `issue_valid` out 1: an entry is selected for issue.
- `issue_ready` in 1: execution unit accepts.
- `issue_payload` out `isq_payload_t`: selected micro-op.
- `count` out `$clog2(DEPTH+1)`: occupied entries.

## Operation
- Per entry: valid, payload, rdy1, rdy2. Ready when `valid & rdy1 & rdy2`.
- Enqueue fires on `enq_valid & enq_ready & !flush`; written into the lowest-index free slot.
- Stored rdyN = `!srcN_is_reg | enq_srcN_ready | wakeup match on prsN this cycle`.
- Wakeup: for each valid entry and each source with `srcN_is_reg`, set rdyN when `wbK_valid & wbK_prd == prsN`. Tag 0 never matches (rename marks p0 ready).
- Age matrix `older[j][i]` (j older than i). Enqueue into slot k: row k cleared, column k set for every other valid entry.
- Select: entry i with ready_i and no ready j having `older[j][i]`. Exactly one or none. `issue_valid` = any ready; `issue_payload` = selected entry's payload (one-hot mux).
- Issue fires on `issue_valid & issue_ready`; that entry's valid clears at the next edge.
- Simultaneous enqueue and issue: both take effect; count unchanged. A slot freed by issue is not reusable for enqueue in that same cycle.
- Flush: all valid cleared next edge; enqueue ignored; `issue_valid` forced 0 during the flush cycle.

## Timing
- Reset values: all valid 0, age matrix 0, `count` 0, `enq_ready` 1, `issue_valid` 0, `issue_payload` 0.
- Enqueue in cycle N gives earliest issue in N+1 (without bypass).
- Wakeup in cycle N gives the entry selectable in N+1. This also holds for a same-cycle wakeup captured at enqueue.
- `issue_valid` and `issue_payload` are combinational from registered state (and, with bypass, from enq inputs). They must hold stable while `issue_ready` is low unless an older entry becomes ready.
- Full: `enq_ready` = 0 while `count == DEPTH`, even if an issue fires that cycle.

## Configuration
- `ISQ_BYPASS_EN` defined: when `count == 0`, the enqueue fires, and both sources are ready (including same-cycle wakeup), the payload is presented on `issue_payload` with `issue_valid` = 1 in the same cycle. If `issue_ready`, the entry is never written; otherwise it is written normally.
- Undefined: no bypass; minimum enqueue-to-issue latency is 1 cycle.

## Structure
- Shared package (`isq_pkg` or the existing defines package): `isq_payload_t` struct, field range macros reused from `defines.sv`, default `DEPTH`/`PREG_W`.
- One sub-module, `age_select`: takes ready vector and age matrix, returns one-hot grant plus any-valid. Combinational and reusable by other queues.

## Test plan
- Reset, then enqueue A (both srcs ready) at cycle 1 with `issue_ready`=1 -> A issues at cycle 2, `count` returns to 0 at cycle 3 (bypass off); with bypass, A issues at cycle 1 and `count` stays 0.
- Enqueue A (prs1=5 not ready), then B (ready) -> B issues first. `wb0_valid`, `wb0_prd`=5 at cycle 5 -> A issues at cycle 6.
- Enqueue A then B, both waiting on p7; wake p7 -> A issues before B (age order), B the next cycle.
- Fill 8 entries with none ready -> `enq_ready`=0, `count`=8. Wake all; issue one with enq_valid held -> enq accepted only the cycle after the issue.
- 4 entries valid, `flush` asserted with enq_valid=1 -> next cycle `count`=0, nothing enqueued, `issue_valid`=0 during the flush cycle.
- Enqueue with prs2=9 in the same cycle as `wb1_prd`=9 -> entry stored ready, issues the next cycle.
